pilha_generica: RTL and testbench
=================================

PILHA_GENERICA -- requirements
Module: pilha_generica

Interface
REQ-001 Parameter DATA_WIDTH, default 16, width of each stored word.
REQ-002 Parameter ADDR_WIDTH, default 10, depth = 2**ADDR_WIDTH entries.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clock  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-low; 0 forces reset state.
REQ-006 push  input  1  push data onto stack this cycle.
REQ-007 pop  input  1  remove top-of-stack this cycle.
REQ-008 clear  input  1  synchronous flush of stack and error flags.
REQ-009 data  input  DATA_WIDTH  word to push.
REQ-010 q  output  DATA_WIDTH  current top-of-stack, registered.
REQ-011 count  output  ADDR_WIDTH+1  number of valid entries, 0..2**ADDR_WIDTH.
REQ-012 empty, full  output  1 each  count==0 / count==2**ADDR_WIDTH, combinational from count.
REQ-013 overflow, underflow  output  1 each  sticky error flags, registered.
REQ-014 watermark  output  ADDR_WIDTH+1  maximum count since reset/clear (see Configuration).

Function
REQ-015 Priority per edge: clear > push/pop; clear SHALL set count=0, q=0, overflow=0, underflow=0, watermark=0.
REQ-016 push only, not full: store data, count+1, q=data at next edge (1-cycle latency).
REQ-017 push only, full: no storage change, count and q unchanged, overflow set to 1.
REQ-018 pop only, count>1: count-1, q=entry previously beneath top at next edge, no bubble.
REQ-019 pop only, count==1: count=0, q=0.
REQ-020 pop only, empty: state unchanged, underflow set to 1.
REQ-021 push and pop, not empty: replace top -- q=data, count unchanged, entries below untouched, no error even when full.
REQ-022 push and pop, empty: treated as push only; count=1, q=data, underflow not set.
REQ-023 Neither push nor pop: all state held; q stable.
REQ-024 overflow/underflow SHALL remain 1 until clear or reset; illegal operations never corrupt stored entries or count.
REQ-025 count SHALL never exceed 2**ADDR_WIDTH nor wrap below 0.
REQ-026 Storage contents need no reset; only count, q, flags and watermark are reset.

Reset
REQ-027 reset=0 SHALL asynchronously force count=0, q=0, overflow=0, underflow=0, watermark=0, regardless of clock.
REQ-028 Reset asserted mid-operation SHALL abandon the in-flight push/pop; first edge after deassertion SHALL execute normally.

Configuration
REQ-029 Macro PILHA_WATERMARK_EN: when defined, watermark SHALL update at each edge to max(watermark, new count).
REQ-030 Without PILHA_WATERMARK_EN, watermark SHALL be constant 0 and no watermark register SHALL be synthesised.

Verification (ADDR_WIDTH=2, DATA_WIDTH=16, depth 4)
REQ-031 Push 0x1111,0x2222,0x3333 -> q follows 0x1111,0x2222,0x3333 one edge after each push; count=3; pop thrice -> q=0x2222,0x1111,0x0000, empty=1.
REQ-032 Push 5 words 0xA0..0xA4 -> count=4, full=1, q=0xA3, overflow=1 after 5th edge; pop -> q=0xA2, overflow still 1.
REQ-033 From reset, pop -> underflow=1, count=0, q=0; then clear -> underflow=0.
REQ-034 Stack 0x10,0x20; push+pop with data 0x99 -> q=0x99, count=2; pop -> q=0x10. At full, push+pop with 0x77 -> q=0x77, overflow=0.
REQ-035 Push 3 words, pull reset low between edges -> q=0, count=0 immediately; release, push 0x5 -> q=0x5, count=1.
REQ-036 With PILHA_WATERMARK_EN: push 3, pop 2, push 1 -> watermark=3; without macro -> watermark=0 throughout.

Source files
------------

// File: rtl/pilha_generica.sv
// Generic LIFO stack with registered top-of-stack output and sticky error flags.
// Optional high-water tracking is enabled by defining PILHA_WATERMARK_EN.
module pilha_generica #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] q,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic                  underflow,
  output logic [ADDR_WIDTH:0]   watermark
);

  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(1) << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] TWO   = (ADDR_WIDTH+1)'(2);

  logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

  logic [ADDR_WIDTH:0]   count_nxt;
  logic [DATA_WIDTH-1:0] q_nxt;
  logic                  overflow_nxt;
  logic                  underflow_nxt;
  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [ADDR_WIDTH:0]   cnt_m1;
  logic [ADDR_WIDTH:0]   cnt_m2;

  function automatic logic [ADDR_WIDTH:0] max_cnt(input logic [ADDR_WIDTH:0] a,
                                                  input logic [ADDR_WIDTH:0] b);
    max_cnt = (a > b) ? a : b;
  endfunction

  assign empty  = (count == '0);
  assign full   = (count == DEPTH);
  assign cnt_m1 = count - ONE;
  assign cnt_m2 = count - TWO;

  always_comb begin
    count_nxt     = count;
    q_nxt         = q;
    overflow_nxt  = overflow;
    underflow_nxt = underflow;
    we            = 1'b0;
    waddr         = count[ADDR_WIDTH-1:0];
    if (clear) begin
      count_nxt     = '0;
      q_nxt         = '0;
      overflow_nxt  = 1'b0;
      underflow_nxt = 1'b0;
    end else if (push && pop && !empty) begin
      // Replace top in place; the entries beneath are untouched and no flag can fire.
      we    = 1'b1;
      waddr = cnt_m1[ADDR_WIDTH-1:0];
      q_nxt = data;
    end else if (push) begin
      if (full) begin
        overflow_nxt = 1'b1;
      end else begin
        we        = 1'b1;
        count_nxt = count + ONE;
        q_nxt     = data;
      end
    end else if (pop) begin
      if (empty) begin
        underflow_nxt = 1'b1;
      end else if (count == ONE) begin
        count_nxt = '0;
        q_nxt     = '0;
      end else begin
        // The word beneath the top is read straight from storage so q has no bubble.
        count_nxt = cnt_m1;
        q_nxt     = mem[cnt_m2[ADDR_WIDTH-1:0]];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count     <= '0;
      q         <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count     <= count_nxt;
      q         <= q_nxt;
      overflow  <= overflow_nxt;
      underflow <= underflow_nxt;
    end
  end

`ifdef PILHA_WATERMARK_EN
  logic [ADDR_WIDTH:0] watermark_r;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)     watermark_r <= '0;
    else if (clear) watermark_r <= '0;
    else            watermark_r <= max_cnt(watermark_r, count_nxt);
  end

  assign watermark = watermark_r;
`else
  assign watermark = '0;
`endif

endmodule

// File: tb/tb_pilha_generica.sv
// Directed self-checking bench for pilha_generica at depth 4 (ADDR_WIDTH=2).
module tb_pilha_generica;

  localparam int DW = 16;
  localparam int AW = 2;

  logic          clock;
  logic          reset;
  logic          push;
  logic          pop;
  logic          clear;
  logic [DW-1:0] data;
  logic [DW-1:0] q;
  logic [AW:0]   count;
  logic          empty;
  logic          full;
  logic          overflow;
  logic          underflow;
  logic [AW:0]   watermark;

  int errors = 0;
  int checks = 0;

`ifdef PILHA_WATERMARK_EN
  localparam bit WM_ON = 1'b1;
`else
  localparam bit WM_ON = 1'b0;
`endif

  pilha_generica #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset(reset), .push(push), .pop(pop), .clear(clear),
    .data(data), .q(q), .count(count), .empty(empty), .full(full),
    .overflow(overflow), .underflow(underflow), .watermark(watermark)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Apply one operation for a single rising edge, then return inputs to idle 1 time unit after it.
  task automatic cyc(input logic ps, input logic pp, input logic cl, input logic [DW-1:0] d);
    @(negedge clock);
    push = ps; pop = pp; clear = cl; data = d;
    @(posedge clock);
    #1;
    push = 1'b0; pop = 1'b0; clear = 1'b0; data = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0; push = 1'b0; pop = 1'b0; clear = 1'b0; data = '0;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (q !== 16'h0) begin errors++; $display("FAIL reset_q got=%h exp=0000", q); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if ({empty, full, overflow, underflow} !== 4'b1000) begin errors++; $display("FAIL reset_flags got=%b exp=1000", {empty, full, overflow, underflow}); end
    checks++; if (watermark !== 3'd0) begin errors++; $display("FAIL reset_wm got=%0d exp=0", watermark); end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_basic();
    logic [DW-1:0] vals [3];
    vals[0] = 16'h1111; vals[1] = 16'h2222; vals[2] = 16'h3333;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 1'b0, vals[i]);
      checks++; if (q !== vals[i]) begin errors++; $display("FAIL basic_push_q%0d got=%h exp=%h", i, q, vals[i]); end
      checks++; if (count !== 3'(i+1)) begin errors++; $display("FAIL basic_push_count%0d got=%0d exp=%0d", i, count, i+1); end
    end
    cyc(1'b0, 1'b0, 1'b0, 16'hFFFF);
    checks++; if (q !== 16'h3333 || count !== 3'd3) begin errors++; $display("FAIL basic_hold got q=%h count=%0d exp q=3333 count=3", q, count); end
    cyc(1'b0, 1'b1, 1'b0, '0);
    checks++; if (q !== 16'h2222 || count !== 3'd2) begin errors++; $display("FAIL basic_pop1 got q=%h count=%0d exp q=2222 count=2", q, count); end
    cyc(1'b0, 1'b1, 1'b0, '0);
    checks++; if (q !== 16'h1111 || count !== 3'd1) begin errors++; $display("FAIL basic_pop2 got q=%h count=%0d exp q=1111 count=1", q, count); end
    cyc(1'b0, 1'b1, 1'b0, '0);
    checks++; if (q !== 16'h0000 || count !== 3'd0) begin errors++; $display("FAIL basic_pop3 got q=%h count=%0d exp q=0000 count=0", q, count); end
    checks++; if (empty !== 1'b1 || underflow !== 1'b0) begin errors++; $display("FAIL basic_empty got empty=%b underflow=%b exp 1 0", empty, underflow); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 16'h00A0 + 16'(i));
    checks++; if (count !== 3'd4 || full !== 1'b1) begin errors++; $display("FAIL ovf_full got count=%0d full=%b exp 4 1", count, full); end
    checks++; if (q !== 16'h00A3) begin errors++; $display("FAIL ovf_q got=%h exp=00a3", q); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    cyc(1'b0, 1'b1, 1'b0, '0);
    checks++; if (q !== 16'h00A2 || count !== 3'd3) begin errors++; $display("FAIL ovf_pop got q=%h count=%0d exp q=00a2 count=3", q, count); end
    checks++; if (overflow !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL ovf_sticky got ovf=%b full=%b exp 1 0", overflow, full); end
    cyc(1'b1, 1'b0, 1'b1, 16'hBEEF);
    checks++; if (count !== 3'd0 || q !== 16'h0 || overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got count=%0d q=%h ovf=%b exp 0 0000 0", count, q, overflow); end
  endtask

  task automatic test_underflow();
    cyc(1'b0, 1'b1, 1'b0, '0);
    checks++; if (underflow !== 1'b1 || count !== 3'd0 || q !== 16'h0) begin errors++; $display("FAIL unf_pop got unf=%b count=%0d q=%h exp 1 0 0000", underflow, count, q); end
    cyc(1'b0, 1'b0, 1'b0, '0);
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL unf_sticky got=%b exp=1", underflow); end
    cyc(1'b0, 1'b0, 1'b1, '0);
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL unf_clear got=%b exp=0", underflow); end
  endtask

  task automatic test_replace();
    cyc(1'b1, 1'b0, 1'b0, 16'h0010);
    cyc(1'b1, 1'b0, 1'b0, 16'h0020);
    cyc(1'b1, 1'b1, 1'b0, 16'h0099);
    checks++; if (q !== 16'h0099 || count !== 3'd2) begin errors++; $display("FAIL rep_q got q=%h count=%0d exp q=0099 count=2", q, count); end
    cyc(1'b0, 1'b1, 1'b0, '0);
    checks++; if (q !== 16'h0010 || count !== 3'd1) begin errors++; $display("FAIL rep_pop got q=%h count=%0d exp q=0010 count=1", q, count); end
    cyc(1'b0, 1'b0, 1'b1, '0);
    for (int i = 1; i <= 4; i++) cyc(1'b1, 1'b0, 1'b0, 16'(i));
    cyc(1'b1, 1'b1, 1'b0, 16'h0077);
    checks++; if (q !== 16'h0077 || count !== 3'd4 || overflow !== 1'b0) begin errors++; $display("FAIL rep_full got q=%h count=%0d ovf=%b exp 0077 4 0", q, count, overflow); end
    cyc(1'b0, 1'b1, 1'b0, '0);
    checks++; if (q !== 16'h0003 || count !== 3'd3) begin errors++; $display("FAIL rep_below got q=%h count=%0d exp q=0003 count=3", q, count); end
    cyc(1'b0, 1'b0, 1'b1, '0);
    cyc(1'b1, 1'b1, 1'b0, 16'h0055);
    checks++; if (q !== 16'h0055 || count !== 3'd1 || underflow !== 1'b0) begin errors++; $display("FAIL rep_empty got q=%h count=%0d unf=%b exp 0055 1 0", q, count, underflow); end
    cyc(1'b0, 1'b0, 1'b1, '0);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 16'h0C00 + 16'(i));
    @(negedge clock);
    push = 1'b1; data = 16'hDEAD;
    #2;
    reset = 1'b0;
    #1;
    checks++; if (q !== 16'h0 || count !== 3'd0) begin errors++; $display("FAIL arst_now got q=%h count=%0d exp q=0000 count=0", q, count); end
    @(posedge clock);
    #1;
    push = 1'b0; data = '0;
    checks++; if (count !== 3'd0 || q !== 16'h0) begin errors++; $display("FAIL arst_hold got q=%h count=%0d exp 0000 0", q, count); end
    @(negedge clock);
    reset = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 16'h0005);
    checks++; if (q !== 16'h0005 || count !== 3'd1) begin errors++; $display("FAIL arst_after got q=%h count=%0d exp q=0005 count=1", q, count); end
    cyc(1'b0, 1'b0, 1'b1, '0);
  endtask

  task automatic test_watermark();
    checks++; if (watermark !== 3'd0) begin errors++; $display("FAIL wm_clear got=%0d exp=0", watermark); end
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 16'h0E00 + 16'(i));
    checks++; if (watermark !== (WM_ON ? 3'd3 : 3'd0)) begin errors++; $display("FAIL wm_peak got=%0d exp=%0d", watermark, WM_ON ? 3 : 0); end
    cyc(1'b0, 1'b1, 1'b0, '0);
    cyc(1'b0, 1'b1, 1'b0, '0);
    cyc(1'b1, 1'b0, 1'b0, 16'h0EEE);
    checks++; if (count !== 3'd2 || q !== 16'h0EEE) begin errors++; $display("FAIL wm_state got count=%0d q=%h exp 2 0eee", count, q); end
    checks++; if (watermark !== (WM_ON ? 3'd3 : 3'd0)) begin errors++; $display("FAIL wm_final got=%0d exp=%0d", watermark, WM_ON ? 3 : 0); end
    cyc(1'b0, 1'b0, 1'b1, '0);
    checks++; if (watermark !== 3'd0) begin errors++; $display("FAIL wm_after_clear got=%0d exp=0", watermark); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_underflow();
    test_replace();
    test_async_reset();
    test_watermark();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
